multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle main control FSM; sits directly upstream of the ALU control decoder.
//  Decodes opcode op[5:0] from the instruction register and sequences fetch/decode/execute/mem/writeback.
//  Drives datapath muxes and strobes plus the 2-bit alu_op consumed by ALU control.
//  Waits on a memory ready handshake; flags faults (memory timeout, optional illegal opcode).
// PARAMETERS
//  MEM_TIMEOUT  15  consecutive not-ready cycles tolerated in a memory state; 0 = never time out
//  CNT_W        4   wait counter width; MEM_TIMEOUT < 2**CNT_W required
// PORTS
//  clk            in   1  rising-edge clock
//  rst_n          in   1  asynchronous reset, active low
//  op             in   6  opcode field, IR[31:26]
//  jr             in   1  jr flag from ALU control (alu_op=10 and funct=8)
//  mem_ready      in   1  memory completes the current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load when ALU zero flag is set (beq)
//  i_or_d         out  1  memory address select: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  instruction register load
//  mem_to_reg     out  1  register write data select: 0=ALUOut, 1=MDR
//  reg_dst        out  1  destination select: 0=rt, 1=rd
//  reg_write      out  1  register file write
//  alu_src_a      out  1  ALU A select: 0=PC, 1=regA
//  alu_src_b      out  2  ALU B select: 00=regB, 01=4, 10=signext imm, 11=imm<<2
//  alu_op         out  2  to ALU control: 00=add, 01=sub, 10=R-format, 11=and
//  pc_source      out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target, 11=regA (jr)
//  state          out  4  current state, for debug
//  fault          out  1  sticky; high while in FAULT
//  illegal_op     out  1  sticky; high when FAULT was entered on an illegal opcode
// BEHAVIOUR
//  Reset: async to FETCH; wait counter = 0; fault = 0; illegal_op = 0.
//  Reset: every output forced 0 while rst_n is low (state reads 0 = FETCH). Reset mid-op abandons the instruction.
//  Outputs are combinational from state (Moore); exception: FETCH ir_write/pc_write = mem_ready.
//  Any output not listed for a state is 0.
//  Encoding/outputs -> next state:
//   0 FETCH:  mem_read, i_or_d=0, a=0, b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready
//             -> DECODE when mem_ready, else stay
//   1 DECODE: a=0, b=11, alu_op=00
//             -> op 0:R=EXEC; op 35/43:lw/sw=MEMADR; op 4:beq=BRANCH; op 2:j=JUMP; op 8/12:addi/andi=IEXEC
//   2 MEMADR: a=1, b=10, alu_op=00 -> MEMRD (op=35) or MEMWR (op=43)
//   3 MEMRD:  mem_read, i_or_d=1 -> MEMWB on mem_ready
//   4 MEMWB:  reg_write, mem_to_reg=1, reg_dst=0 -> FETCH
//   5 MEMWR:  mem_write, i_or_d=1 -> FETCH on mem_ready
//   6 EXEC:   a=1, b=00, alu_op=10 -> JR if jr, else RWB
//   7 RWB:    reg_write, reg_dst=1, mem_to_reg=0 -> FETCH
//   8 BRANCH: a=1, b=00, alu_op=01, pc_write_cond, pc_source=01 -> FETCH
//   9 JUMP:   pc_write, pc_source=10 -> FETCH
//  10 IEXEC:  a=1, b=10, alu_op=00 (op 8) or 11 (op 12) -> IWB
//  11 IWB:    reg_write, reg_dst=0, mem_to_reg=0, alu_op as IEXEC -> FETCH
//  12 JR:     pc_write, pc_source=11 -> FETCH
//  15 FAULT:  all strobes 0; fault=1; exited only by reset
//  Wait counter:
//   - increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0; cleared on every state change
//   - when it equals MEM_TIMEOUT-1 and mem_ready=0, next state is FAULT (i.e. the MEM_TIMEOUT-th miss)
//   - mem_ready=1 on that same cycle wins: normal transition, no fault
//  Latency: R 4 cycles, lw 5, sw 4, beq 3, j 3, addi/andi 4, jr 4 (zero wait states).
//  op is held stable by IR outside FETCH; the FSM does not latch it.
//  Unused codes 13, 14 recover to FETCH.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined:
//   - unknown opcode in DECODE -> FAULT with illegal_op=1
//   - MEMADR with op not 35/43 cannot occur
//  CTRL_ILLEGAL_TRAP_EN undefined:
//   - unknown opcode treated as NOP: DECODE -> FETCH; illegal_op tied 0
// TESTING
//  1 Reset: rst_n=0 mid-MEMRD, then release -> state=0, every strobe 0 during reset, mem_read=1 after release.
//  2 lw, op=35, mem_ready always 1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in cycle 5.
//  3 R-type, op=0, jr=0: EXEC shows alu_op=10 -> RWB with reg_dst=1; again with jr=1 -> JR, pc_write=1, pc_source=11.
//  4 andi, op=12 -> IEXEC/IWB alu_op=11; addi, op=8 -> alu_op=00; beq, op=4 -> alu_op=01, pc_write_cond=1.
//  5 sw with mem_ready low 3 cycles -> MEMWR held 4 cycles; low 15 cycles (default) -> FAULT, fault=1 until reset.
//  6 op=63: trap build -> FAULT with illegal_op=1; non-trap build -> FETCH after DECODE, illegal_op=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: fetch/decode/execute/mem/writeback sequencing with memory-ready wait and timeout fault.
// Optional illegal-opcode trap enabled by defining CTRL_ILLEGAL_TRAP_EN.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       jr,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       fault,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11,
        JR     = 4'd12,
        FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_ANDI = 6'd12;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_wait;
    logic             timeout_hit;
    logic [1:0]       imm_alu_op;

    // MEM_TIMEOUT of 0 disables the timeout entirely
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);
    assign mem_wait    = !mem_ready &&
                         ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR));
    assign imm_alu_op  = (op == OP_ANDI) ? 2'b11 : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (state_q == DECODE && state_d == FAULT)
            illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign state = state_q;
    assign fault = (state_q == FAULT);

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;

        // Outputs stay quiet while reset is held, even though FETCH is the reset state
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready)        state_d = DECODE;
                    else if (timeout_hit) state_d = FAULT;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (op)
                        OP_R:           state_d = EXEC;
                        OP_LW, OP_SW:   state_d = MEMADR;
                        OP_BEQ:         state_d = BRANCH;
                        OP_J:           state_d = JUMP;
                        OP_ADDI, OP_ANDI: state_d = IEXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:        state_d = FAULT;
`else
                        default:        state_d = FETCH;
`endif
                    endcase
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (op == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready)        state_d = MEMWB;
                    else if (timeout_hit) state_d = FAULT;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = FETCH;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready)        state_d = FETCH;
                    else if (timeout_hit) state_d = FAULT;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = jr ? JR : RWB;
                end
                RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = FETCH;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    state_d       = FETCH;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    state_d   = FETCH;
                end
                IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = imm_alu_op;
                    state_d   = IWB;
                end
                IWB: begin
                    reg_write = 1'b1;
                    alu_op    = imm_alu_op;
                    state_d   = FETCH;
                end
                JR: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b11;
                    state_d   = FETCH;
                end
                FAULT:   state_d = FAULT;
                default: state_d = FETCH;
            endcase
        end

        // Counter measures consecutive misses within one memory state only
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (mem_wait)
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        else
            wait_cnt_d = wait_cnt_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table with a scoreboard queue checked mid-cycle.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       jr;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       fault, illegal_op;

    multicycle_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .jr           (jr),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .state        (state),
        .fault        (fault),
        .illegal_op   (illegal_op)
    );

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic [3:0] state;
        logic       fault, illegal_op;
    } out_t;

    typedef struct packed {
        logic       rst_n;
        logic [5:0] op;
        logic       jr;
        logic       mem_ready;
        logic [3:0] st;
        logic       ill;
    } vec_t;

    typedef struct packed {
        out_t        e;
        logic        rst_n;
        logic [15:0] id;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [5:0] o, input logic j,
                       input logic mr, input logic [3:0] st, input logic ill);
        vec_t v;
        v.rst_n = r; v.op = o; v.jr = j; v.mem_ready = mr; v.st = st; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic [5:0] o, input logic mr, input logic [3:0] st);
        for (int k = 0; k < n; k++) add(1'b1, o, 1'b0, mr, st, 1'b0);
    endtask

    // Expected outputs for a cycle, taken from the per-state output table
    function automatic out_t expect_out(input vec_t v);
        out_t o;
        o = '0;
        if (v.rst_n) begin
            o.state = v.st;
            case (v.st)
                4'd0:  begin o.mem_read = 1; o.alu_src_b = 2'b01;
                             o.ir_write = v.mem_ready; o.pc_write = v.mem_ready; end
                4'd1:  o.alu_src_b = 2'b11;
                4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
                4'd3:  begin o.mem_read = 1; o.i_or_d = 1; end
                4'd4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
                4'd5:  begin o.mem_write = 1; o.i_or_d = 1; end
                4'd6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
                4'd7:  begin o.reg_write = 1; o.reg_dst = 1; end
                4'd8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
                4'd9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
                4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10;
                             o.alu_op = (v.op == 6'd12) ? 2'b11 : 2'b00; end
                4'd11: begin o.reg_write = 1; o.alu_op = (v.op == 6'd12) ? 2'b11 : 2'b00; end
                4'd12: begin o.pc_write = 1; o.pc_source = 2'b11; end
                4'd15: o.fault = 1;
                default: ;
            endcase
            o.illegal_op = v.ill;
        end
        return o;
    endfunction

    always @(negedge clk) begin
        sb_t  s;
        out_t act;
        #2;
        if (sbq.size() > 0) begin
            s   = sbq.pop_front();
            act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, state, fault, illegal_op};
            checks++;
            if (act !== s.e) begin
                errors++;
                $display("FAIL vec%0d: outputs got %h (state %0d) expected %h (state %0d)",
                         s.id, act, act.state, s.e, s.e.state);
            end
            if (!s.rst_n && act !== '0) begin
                errors++;
                $display("FAIL vec%0d: outputs not all zero during reset (got %h)", s.id, act);
            end
            if (s.e.fault && (fault !== 1'b1 || state !== 4'd15)) begin
                errors++;
                $display("FAIL vec%0d: expired wait did not hold FAULT (fault=%b state=%0d)",
                         s.id, fault, state);
            end
        end
    end

    initial begin
        sb_t s;
        rst_n = 1'b0; op = '0; jr = 1'b0; mem_ready = 1'b0;

        // Reset held: everything zero
        add(0, 6'd35, 0, 1, 4'd0, 0);
        add(0, 6'd35, 0, 1, 4'd0, 0);
        // lw, zero wait: 0,1,2,3,4
        add(1, 6'd35, 0, 1, 4'd0, 0); add(1, 6'd35, 0, 1, 4'd1, 0);
        add(1, 6'd35, 0, 1, 4'd2, 0); add(1, 6'd35, 0, 1, 4'd3, 0);
        add(1, 6'd35, 0, 1, 4'd4, 0);
        // R-type, jr=0 then jr=1
        add(1, 6'd0, 0, 1, 4'd0, 0); add(1, 6'd0, 0, 1, 4'd1, 0);
        add(1, 6'd0, 0, 1, 4'd6, 0); add(1, 6'd0, 0, 1, 4'd7, 0);
        add(1, 6'd0, 1, 1, 4'd0, 0); add(1, 6'd0, 1, 1, 4'd1, 0);
        add(1, 6'd0, 1, 1, 4'd6, 0); add(1, 6'd0, 1, 1, 4'd12, 0);
        // andi, addi, beq, j
        add(1, 6'd12, 0, 1, 4'd0, 0); add(1, 6'd12, 0, 1, 4'd1, 0);
        add(1, 6'd12, 0, 1, 4'd10, 0); add(1, 6'd12, 0, 1, 4'd11, 0);
        add(1, 6'd8, 0, 1, 4'd0, 0); add(1, 6'd8, 0, 1, 4'd1, 0);
        add(1, 6'd8, 0, 1, 4'd10, 0); add(1, 6'd8, 0, 1, 4'd11, 0);
        add(1, 6'd4, 0, 1, 4'd0, 0); add(1, 6'd4, 0, 1, 4'd1, 0); add(1, 6'd4, 0, 1, 4'd8, 0);
        add(1, 6'd2, 0, 1, 4'd0, 0); add(1, 6'd2, 0, 1, 4'd1, 0); add(1, 6'd2, 0, 1, 4'd9, 0);
        // FETCH waits two cycles, then sw with three wait states in MEMWR
        add_n(2, 6'd43, 0, 4'd0);
        add(1, 6'd43, 0, 1, 4'd0, 0); add(1, 6'd43, 0, 1, 4'd1, 0); add(1, 6'd43, 0, 1, 4'd2, 0);
        add_n(3, 6'd43, 0, 4'd5);
        add(1, 6'd43, 0, 1, 4'd5, 0);
        // lw with 14 misses in MEMRD; ready on the 15th cycle wins over the timeout
        add(1, 6'd35, 0, 1, 4'd0, 0); add(1, 6'd35, 0, 1, 4'd1, 0); add(1, 6'd35, 0, 1, 4'd2, 0);
        add_n(14, 6'd35, 0, 4'd3);
        add(1, 6'd35, 0, 1, 4'd3, 0); add(1, 6'd35, 0, 1, 4'd4, 0);
        // Reset in the middle of MEMRD abandons the load
        add(1, 6'd35, 0, 1, 4'd0, 0); add(1, 6'd35, 0, 1, 4'd1, 0); add(1, 6'd35, 0, 1, 4'd2, 0);
        add_n(2, 6'd35, 0, 4'd3);
        add(0, 6'd35, 0, 0, 4'd0, 0);
        add(1, 6'd35, 0, 0, 4'd0, 0);
        add(1, 6'd35, 0, 1, 4'd0, 0); add(1, 6'd35, 0, 1, 4'd1, 0);
        add(1, 6'd35, 0, 1, 4'd2, 0); add(1, 6'd35, 0, 1, 4'd3, 0); add(1, 6'd35, 0, 1, 4'd4, 0);
        // Unknown opcode 63
        add(1, 6'd63, 0, 1, 4'd0, 0); add(1, 6'd63, 0, 1, 4'd1, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        add(1, 6'd63, 0, 1, 4'd15, 1); add(1, 6'd63, 0, 1, 4'd15, 1);
`else
        add(1, 6'd63, 0, 1, 4'd0, 0); add(1, 6'd63, 0, 1, 4'd1, 0);
`endif
        add(0, 6'd0, 0, 1, 4'd0, 0);
        // sw timing out after 15 consecutive misses; fault sticks until reset
        add(1, 6'd43, 0, 1, 4'd0, 0); add(1, 6'd43, 0, 1, 4'd1, 0); add(1, 6'd43, 0, 1, 4'd2, 0);
        add_n(15, 6'd43, 0, 4'd5);
        add_n(3, 6'd43, 1, 4'd15);
        add(0, 6'd43, 0, 1, 4'd0, 0);
        add(1, 6'd43, 0, 1, 4'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n     = vecs[i].rst_n;
            op        = vecs[i].op;
            jr        = vecs[i].jr;
            mem_ready = vecs[i].mem_ready;
            s.e     = expect_out(vecs[i]);
            s.rst_n = vecs[i].rst_n;
            s.id    = 16'(i);
            sbq.push_back(s);
        end
        @(negedge clk);
        #5;
        if (checks != vecs.size()) begin
            errors++;
            $display("FAIL: ran %0d checks, expected %0d", checks, vecs.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
